// File: rtl/mips_core_pkg.sv
// Shared MIPS core types and sizing constants used by the commit store buffer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mips_core_pkg;

  localparam int STORE_BUF_DEPTH = 8;
  localparam int SB_ADDR_WIDTH   = 32;
  localparam int SB_DATA_WIDTH   = 32;

  // One committed store as it is held in the buffer.
  typedef struct packed {
    logic                     valid;
    logic [SB_ADDR_WIDTH-1:0] addr;
    logic [SB_DATA_WIDTH-1:0] data;
  } StoreBufEntry;

endpackage

// File: rtl/store_buf_fwd_search.sv
// Age-ordered word-address match of a load against the store buffer plus the in-flight write.
// Latency: purely combinational, 0 cycles.
// Backpressure: none; it only observes buffer state.
module store_buf_fwd_search #(
  parameter int DEPTH      = 8,
  parameter int WORD_WIDTH = 30,
  parameter int DATA_WIDTH = 32,
  parameter int PW         = $clog2(DEPTH)
) (
  input  logic [DEPTH-1:0]      ent_valid,
  input  logic [WORD_WIDTH-1:0] ent_word [DEPTH],
  input  logic [DATA_WIDTH-1:0] ent_data [DEPTH],
  input  logic [PW-1:0]         head,
  input  logic [PW-1:0]         tail,
  input  logic                  wr_en,
  input  logic [WORD_WIDTH-1:0] wr_word,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [WORD_WIDTH-1:0] ld_word,
  output logic                  hit,
  output logic [DATA_WIDTH-1:0] data
);

  logic [PW-1:0] idx;
  logic          done;

  // Walk from the youngest stored entry (tail-1) back to head; the first valid match wins,
  // and a matching incoming write outranks everything already stored.
  always_comb begin
    hit  = 1'b0;
    data = '0;
    done = 1'b0;
    idx  = '0;
    if (wr_en && (wr_word == ld_word)) begin
      hit  = 1'b1;
      data = wr_data;
      done = 1'b1;
    end
    for (int i = 0; i < DEPTH; i++) begin
      idx = tail - PW'(1) - PW'(i);
      if (!done) begin
        if (ent_valid[idx] && (ent_word[idx] == ld_word)) begin
          hit  = 1'b1;
          data = ent_data[idx];
          done = 1'b1;
        end
        if (idx == head) begin
          done = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/commit_store_buffer.sv
// In-order FIFO of committed stores draining to the D-cache, with store-to-load forwarding.
// Latency: an enqueued store is visible on dc_valid the next cycle; forwarding is combinational.
// Backpressure: dc_stall holds the head stable; when full the ROB may commit only alongside a drain, else the write is dropped and overflow sticks.
module commit_store_buffer
  import mips_core_pkg::*;
#(
  parameter int DEPTH      = STORE_BUF_DEPTH,
  parameter int ADDR_WIDTH = SB_ADDR_WIDTH,
  parameter int DATA_WIDTH = SB_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mem_wr_en,
  input  logic [ADDR_WIDTH-1:0] mem_wr_addr,
  input  logic [DATA_WIDTH-1:0] mem_wr_data,
  output logic                  full,
  output logic                  empty,
  output logic                  overflow,
  output logic                  dc_valid,
  output logic [ADDR_WIDTH-1:0] dc_addr,
  output logic [DATA_WIDTH-1:0] dc_data,
  input  logic                  dc_stall,
  input  logic [ADDR_WIDTH-1:0] ld_addr,
  output logic                  fwd_hit,
  output logic [DATA_WIDTH-1:0] fwd_data
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int WW = ADDR_WIDTH - 2;
  localparam logic [CW-1:0] DEPTH_CNT = CW'(DEPTH);

  logic [PW-1:0]         head;
  logic [PW-1:0]         tail;
  logic [CW-1:0]         count;
  logic [DEPTH-1:0]      ent_valid;
  logic [ADDR_WIDTH-1:0] ent_addr [DEPTH];
  logic [DATA_WIDTH-1:0] ent_data [DEPTH];
  logic [WW-1:0]         ent_word [DEPTH];
  logic                  enq;
  logic                  deq;
  logic                  unused_ld_byte_bits;

  // Status and drain outputs come only from registered state, never from inputs.
  assign full     = (count == DEPTH_CNT);
  assign empty    = (count == '0);
  assign dc_valid = ~empty;
  assign dc_addr  = empty ? '0 : ent_addr[head];
  assign dc_data  = empty ? '0 : ent_data[head];

  // A drain frees a slot in the same cycle, so a full buffer can still accept a commit.
  assign deq = dc_valid & ~dc_stall;
  assign enq = mem_wr_en & (~full | deq);

  // Forwarding is word-granular: byte offset bits do not take part in the match.
  assign unused_ld_byte_bits = ^ld_addr[1:0];

  genvar g;
  generate
    for (g = 0; g < DEPTH; g++) begin : g_word
      assign ent_word[g] = ent_addr[g][ADDR_WIDTH-1:2];
    end
  endgenerate

  // Pointers, occupancy, per-entry valid bits and the sticky overflow flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      head      <= '0;
      tail      <= '0;
      count     <= '0;
      ent_valid <= '0;
      overflow  <= 1'b0;
    end else begin
      if (deq) begin
        ent_valid[head] <= 1'b0;
        head            <= head + PW'(1);
      end
      // Placed after the dequeue so a full-buffer enq+deq on the same slot leaves it valid.
      if (enq) begin
        ent_valid[tail] <= 1'b1;
        tail            <= tail + PW'(1);
      end
      case ({enq, deq})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (mem_wr_en && full && !deq) begin
        overflow <= 1'b1;
      end
    end
  end

  // Entry payload; validity is tracked separately so the payload needs no reset.
  always_ff @(posedge clk) begin
    if (enq) begin
      ent_addr[tail] <= mem_wr_addr;
      ent_data[tail] <= mem_wr_data;
    end
  end

  store_buf_fwd_search #(
    .DEPTH      (DEPTH),
    .WORD_WIDTH (WW),
    .DATA_WIDTH (DATA_WIDTH),
    .PW         (PW)
  ) u_fwd_search (
    .ent_valid (ent_valid),
    .ent_word  (ent_word),
    .ent_data  (ent_data),
    .head      (head),
    .tail      (tail),
    .wr_en     (mem_wr_en),
    .wr_word   (mem_wr_addr[ADDR_WIDTH-1:2]),
    .wr_data   (mem_wr_data),
    .ld_word   (ld_addr[ADDR_WIDTH-1:2]),
    .hit       (fwd_hit),
    .data      (fwd_data)
  );

endmodule

// File: tb/tb_commit_store_buffer.sv
// Directed bench for commit_store_buffer: reset, stall hold, fill/overflow, full enq+deq, forwarding, wrap stress.
// Latency: checks one-cycle enqueue-to-drain visibility.
// Backpressure: drives dc_stall and obeys full on the commit side.
module tb_commit_store_buffer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_wr_en = 1'b0;
  logic [31:0] mem_wr_addr = '0;
  logic [31:0] mem_wr_data = '0;
  logic        full;
  logic        empty;
  logic        overflow;
  logic        dc_valid;
  logic [31:0] dc_addr;
  logic [31:0] dc_data;
  logic        dc_stall = 1'b0;
  logic [31:0] ld_addr = '0;
  logic        fwd_hit;
  logic [31:0] fwd_data;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  commit_store_buffer #(
    .DEPTH      (8),
    .ADDR_WIDTH (32),
    .DATA_WIDTH (32)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .mem_wr_en   (mem_wr_en),
    .mem_wr_addr (mem_wr_addr),
    .mem_wr_data (mem_wr_data),
    .full        (full),
    .empty       (empty),
    .overflow    (overflow),
    .dc_valid    (dc_valid),
    .dc_addr     (dc_addr),
    .dc_data     (dc_data),
    .dc_stall    (dc_stall),
    .ld_addr     (ld_addr),
    .fwd_hit     (fwd_hit),
    .fwd_data    (fwd_data)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    mem_wr_en   = 1'b1;
    mem_wr_addr = a;
    mem_wr_data = d;
  endtask

  logic [31:0] exp_a [$];
  logic [31:0] exp_d [$];
  logic [31:0] pa;
  logic [31:0] pd;

  initial begin
    int sent;
    int got;
    int cyc;

    tick();
    tick();
    rst = 1'b0;

    // Reset in the middle of traffic with three entries queued.
    dc_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      wr(32'h500 + 32'(i * 4), 32'hA0 + 32'(i));
      tick();
    end
    mem_wr_en = 1'b0;
    ld_addr   = 32'h500;
    settle();
    chk("pre_rst_valid", dc_valid, 1);
    chk("pre_rst_hit", fwd_hit, 1);
    chk("pre_rst_fwd", fwd_data, 32'hA0);
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    settle();
    chk("rst_empty", empty, 1);
    chk("rst_valid", dc_valid, 0);
    chk("rst_full", full, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_hit", fwd_hit, 0);
    chk("rst_fwd", fwd_data, 0);
    chk("rst_addr", dc_addr, 0);
    chk("rst_data", dc_data, 0);

    // Single store held under stall, then drained.
    wr(32'h100, 32'hDEADBEEF);
    settle();
    chk("t2_no_comb_path", dc_valid, 0);
    tick();
    mem_wr_en = 1'b0;
    settle();
    chk("t2_valid", dc_valid, 1);
    chk("t2_addr", dc_addr, 32'h100);
    chk("t2_data", dc_data, 32'hDEADBEEF);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("t2_hold_valid", dc_valid, 1);
      chk("t2_hold_addr", dc_addr, 32'h100);
      chk("t2_hold_data", dc_data, 32'hDEADBEEF);
    end
    dc_stall = 1'b0;
    tick();
    dc_stall = 1'b1;
    settle();
    chk("t2_empty", empty, 1);
    chk("t2_valid_off", dc_valid, 0);

    // Fill to eight, then a ninth write is dropped.
    for (int i = 0; i < 8; i++) begin
      wr(32'h1000 + 32'(i * 4), 32'h11110000 + 32'(i));
      tick();
    end
    mem_wr_en = 1'b0;
    settle();
    chk("t3_full", full, 1);
    chk("t3_not_empty", empty, 0);
    chk("t3_no_ovf", overflow, 0);
    wr(32'h2000, 32'h99);
    tick();
    mem_wr_en = 1'b0;
    ld_addr   = 32'h2000;
    settle();
    chk("t3_ovf", overflow, 1);
    chk("t3_still_full", full, 1);
    chk("t3_head_kept", dc_addr, 32'h1000);
    chk("t3_dropped_not_fwd", fwd_hit, 0);

    // Full buffer, drain and commit in the same cycle.
    dc_stall = 1'b0;
    wr(32'h300, 32'h3333);
    settle();
    chk("t4_head0_addr", dc_addr, 32'h1000);
    chk("t4_head0_data", dc_data, 32'h11110000);
    tick();
    mem_wr_en = 1'b0;
    settle();
    chk("t4_full_kept", full, 1);
    chk("t4_ovf_sticky", overflow, 1);
    for (int i = 1; i < 8; i++) begin
      chk("t4_order_addr", dc_addr, 32'h1000 + 32'(i * 4));
      chk("t4_order_data", dc_data, 32'h11110000 + 32'(i));
      tick();
    end
    chk("t4_last_addr", dc_addr, 32'h300);
    chk("t4_last_data", dc_data, 32'h3333);
    tick();
    chk("t4_empty", empty, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    settle();
    chk("ovf_cleared", overflow, 0);

    // Forwarding priority.
    dc_stall = 1'b1;
    wr(32'h200, 32'h1);
    tick();
    wr(32'h200, 32'h2);
    tick();
    mem_wr_en = 1'b0;
    ld_addr   = 32'h202;
    settle();
    chk("t5_hit", fwd_hit, 1);
    chk("t5_youngest", fwd_data, 32'h2);
    wr(32'h200, 32'h3);
    settle();
    chk("t5_incoming_hit", fwd_hit, 1);
    chk("t5_incoming", fwd_data, 32'h3);
    mem_wr_en = 1'b0;
    ld_addr   = 32'h204;
    settle();
    chk("t5_miss_hit", fwd_hit, 0);
    chk("t5_miss_data", fwd_data, 0);
    ld_addr  = 32'h200;
    dc_stall = 1'b0;
    settle();
    chk("t5_drain_fwd", fwd_data, 32'h2);
    tick();
    chk("t5_deq_head_hit", fwd_hit, 1);
    chk("t5_deq_head_data", fwd_data, 32'h2);
    tick();
    chk("t5_empty", empty, 1);
    chk("t5_gone", fwd_hit, 0);

    // Wrap-around stress with random stall and a well-behaved ROB.
    sent = 0;
    got  = 0;
    cyc  = 0;
    while (got < 40 && cyc < 3000) begin
      dc_stall  = ($urandom_range(0, 2) != 0);
      mem_wr_en = 1'b0;
      if (sent < 40 && (!full || (dc_valid && !dc_stall))) begin
        wr(32'h4000 + 32'(sent) * 32'd4, $urandom);
        exp_a.push_back(mem_wr_addr);
        exp_d.push_back(mem_wr_data);
        sent++;
      end
      settle();
      if (dc_valid && !dc_stall) begin
        if (exp_a.size() == 0) begin
          chk("t6_spurious_drain", dc_valid, 0);
        end else begin
          pa = exp_a.pop_front();
          pd = exp_d.pop_front();
          chk("t6_addr", dc_addr, pa);
          chk("t6_data", dc_data, pd);
        end
        got++;
      end
      tick();
      cyc++;
    end
    mem_wr_en = 1'b0;
    dc_stall  = 1'b1;
    settle();
    chk("t6_drained", got, 40);
    chk("t6_ovf", overflow, 0);
    chk("t6_empty", empty, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
